// File: rtl/video_stream_tx_pkg.sv
// Shared types and constants for the pixel-stream transmitter.
// Holds the pixel width, default frame geometry and the 2-bit TX state encodings.
package video_stream_tx_pkg;

    localparam int PIXEL_SIZE       = 24;
    localparam int WORD_SIZE        = 32;
    localparam int FRAME_WIDTH_DEF  = 640;
    localparam int FRAME_HEIGHT_DEF = 480;

    typedef logic [PIXEL_SIZE-1:0] pixel_t;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_ACTIVE = 2'd1,
        TX_HBLANK = 2'd2,
        TX_VBLANK = 2'd3
    } tx_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A dimension of 1 still needs a 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_stream_tx_blank_counter.sv
// Loadable down-counter timing both horizontal and vertical blanking.
// Loaded with N-1 on entry to a blank state; done while the count sits at zero.
module blank_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = value;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/video_stream_tx.sv
// Pixel-stream transmitter: valid/ready pixels in, en/hsync/vsync/data out,
// with programmable horizontal and vertical blanking and a 1-cycle pixel latency.
module video_stream_tx
    import video_stream_tx_pkg::*;
#(
    parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
    parameter int FRAME_HEIGHT = FRAME_HEIGHT_DEF,
    parameter int H_BLANK      = 16,
    parameter int V_BLANK      = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic        in_valid,
    input  pixel_t      in_data,
    output logic        in_ready,
    output logic        en,
    output logic        hsync,
    output logic        vsync,
    output pixel_t      data,
    output logic        busy,
    output logic        underrun,
    output logic [31:0] frame
);

    localparam int XW = cnt_w(FRAME_WIDTH);
    localparam int YW = cnt_w(FRAME_HEIGHT);
    localparam int BW = $clog2(max_int(H_BLANK, V_BLANK) + 1);
    localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

    tx_state_t       state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            en_q, hsync_q, vsync_q, busy_q, underrun_q;
    pixel_t          data_q;
    logic [31:0]     frame_q;
    logic            accept, line_end, frame_end;
    logic            blank_load, blank_done;
    logic [BW-1:0]   blank_value;

    assign accept    = in_ready & in_valid;
    assign line_end  = accept && (x_q == X_LAST);
    assign frame_end = line_end && (y_q == Y_LAST);

    always_ff @(posedge clk) begin
        if (!reset_n)
            state_q <= TX_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:   if (run) state_d = TX_ACTIVE;
            TX_ACTIVE: begin
                if (frame_end)     state_d = TX_VBLANK;
                else if (line_end) state_d = TX_HBLANK;
            end
            TX_HBLANK: if (blank_done) state_d = TX_ACTIVE;
            TX_VBLANK: if (blank_done) state_d = run ? TX_ACTIVE : TX_IDLE;
            default:   state_d = TX_IDLE;
        endcase
    end

    // in_ready is a pure state decode so it never loops back through in_valid.
    always_comb begin
        in_ready    = (state_q == TX_ACTIVE);
        blank_load  = line_end;
        blank_value = frame_end ? BW'(V_BLANK - 1) : BW'(H_BLANK - 1);
    end

    blank_counter #(.WIDTH(BW)) u_blank (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (blank_load),
        .value   (blank_value),
        .done    (blank_done)
    );

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (line_end) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else if (accept) begin
            x_d = x_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x_q        <= '0;
            y_q        <= '0;
            en_q       <= 1'b0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
            frame_q    <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            en_q    <= accept;
            hsync_q <= accept && (x_q == '0);
            vsync_q <= accept && (x_q == '0) && (y_q == '0);
            data_q  <= accept ? in_data : '0;
            busy_q  <= (state_d != TX_IDLE);
            if (state_q == TX_IDLE && run)
                underrun_q <= 1'b0;
            else if (state_q == TX_ACTIVE && !in_valid)
                underrun_q <= 1'b1;
            if (frame_end)
                frame_q <= frame_q + 32'd1;
        end
    end

    assign en       = en_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign data     = data_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;
    assign frame    = frame_q;

endmodule

// File: tb/tb_video_stream_tx.sv
// Self-checking bench for video_stream_tx on a 4x3 frame with H_BLANK=2, V_BLANK=3.
// Expected behaviour comes from a pixel-index/phase model of the frame timeline.
module tb_video_stream_tx;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HB = 2;
    localparam int VB = 3;
    localparam int PERIOD = W * H + (H - 1) * HB + VB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        run = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_ready, en, hsync, vsync, busy, underrun;
    logic [23:0] data;
    logic [31:0] frame;

    video_stream_tx #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .en       (en),
        .hsync    (hsync),
        .vsync    (vsync),
        .data     (data),
        .busy     (busy),
        .underrun (underrun),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef enum {M_IDLE, M_ACT, M_GAP} mmode_t;
    mmode_t      m_mode = M_IDLE;
    int          m_idx = 0, m_gap = 0;
    bit          m_vgap = 1'b0;
    logic        e_en = 0, e_hs = 0, e_vs = 0, e_busy = 0, e_under = 0;
    logic [23:0] e_data = '0;
    logic [31:0] e_frame = '0;
    logic [23:0] next_pix = 24'd1;
    int          cyc_n = 0, n_en = 0, n_acc = 0;
    int          vs_t[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = M_IDLE; m_idx = 0; m_gap = 0; m_vgap = 1'b0;
        e_en = 0; e_hs = 0; e_vs = 0; e_busy = 0; e_under = 0;
        e_data = '0; e_frame = '0;
    endtask

    // One clock: check outputs of the previous edge, drive inputs, advance model.
    task automatic cyc(input bit rst, input bit r, input bit v);
        bit acc;
        @(posedge clk); #1;
        cyc_n++;
        chk("en", 32'(en), 32'(e_en));
        chk("data", 32'(data), 32'(e_data));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("underrun", 32'(underrun), 32'(e_under));
        chk("frame", frame, e_frame);
        chk("in_ready", 32'(in_ready), 32'(m_mode == M_ACT));
        if (en) n_en++;
        if (en && vsync) vs_t.push_back(cyc_n);
        reset_n  = !rst;
        run      = r;
        in_valid = v;
        in_data  = next_pix;
        if (rst) begin
            m_reset();
            return;
        end
        acc    = (m_mode == M_ACT) && v;
        e_en   = acc;
        e_data = acc ? next_pix : 24'd0;
        e_hs   = acc && (m_idx % W == 0);
        e_vs   = acc && (m_idx == 0);
        case (m_mode)
            M_IDLE: if (r) begin m_mode = M_ACT; e_under = 1'b0; end
            M_ACT: begin
                if (!v) e_under = 1'b1;
                else begin
                    m_idx++;
                    if (m_idx == W * H) begin
                        m_idx = 0; m_mode = M_GAP; m_gap = VB; m_vgap = 1'b1; e_frame++;
                    end else if (m_idx % W == 0) begin
                        m_mode = M_GAP; m_gap = HB; m_vgap = 1'b0;
                    end
                end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) m_mode = (!m_vgap || r) ? M_ACT : M_IDLE;
            end
        endcase
        if (acc) begin
            next_pix++;
            n_acc++;
        end
        e_busy = (m_mode != M_IDLE);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        next_pix = 24'd1;
        n_en = 0; n_acc = 0;
        vs_t.delete();
    endtask

    initial begin
        int stall_cnt;
        bit v;

        // Reset state
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame", frame, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        do_reset();

        // Single frame, run pulsed for one cycle
        cyc(0, 1, 1);
        repeat (30) cyc(0, 0, 1);
        chk("single_en_count", 32'(n_en), 32'(W * H));
        chk("single_vsync_count", 32'(vs_t.size()), 32'd1);
        chk("single_frame", frame, 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // Continuous run: vsync spacing equals the frame period
        do_reset();
        repeat (70) cyc(0, 1, 1);
        repeat (25) cyc(0, 0, 1);
        chk("cont_vsync_count", 32'(vs_t.size() >= 3), 32'd1);
        for (int i = 1; i < vs_t.size(); i++)
            chk("cont_period", 32'(vs_t[i] - vs_t[i-1]), 32'(PERIOD));
        chk("cont_idle", 32'(busy), 32'd0);

        // Stall three cycles while pixel 6 is offered
        do_reset();
        stall_cnt = 0;
        for (int i = 0; i < 45; i++) begin
            v = 1'b1;
            if (next_pix == 24'd6 && m_mode == M_ACT && stall_cnt < 3) begin
                v = 1'b0;
                stall_cnt++;
            end
            cyc(0, 1, v);
        end
        repeat (25) cyc(0, 0, 1);
        chk("stall_vsync_count", 32'(vs_t.size() >= 2), 32'd1);
        if (vs_t.size() >= 2)
            chk("stall_period", 32'(vs_t[1] - vs_t[0]), 32'(PERIOD + 3));
        chk("stall_underrun_held", 32'(underrun), 32'd1);
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        chk("stall_underrun_clear", 32'(underrun), 32'd0);
        repeat (25) cyc(0, 0, 1);

        // Reset mid-frame after pixel 7
        do_reset();
        cyc(0, 1, 1);
        for (int i = 0; i < 40 && next_pix != 24'd8; i++) cyc(0, 0, 1);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_en", 32'(en), 32'd0);
        next_pix = 24'd1; n_en = 0; vs_t.delete();
        cyc(0, 1, 1);
        repeat (30) cyc(0, 0, 1);
        chk("midrst_refill_count", 32'(n_en), 32'(W * H));
        chk("midrst_vsync_count", 32'(vs_t.size()), 32'd1);

        // Run dropped at pixel 2
        do_reset();
        cyc(0, 1, 1);
        for (int i = 0; i < 10 && next_pix != 24'd3; i++) cyc(0, 1, 1);
        repeat (30) cyc(0, 0, 1);
        chk("drop_en_count", 32'(n_en), 32'(W * H));
        chk("drop_frame", frame, 32'd1);
        chk("drop_busy", 32'(busy), 32'd0);

        // Random valid and run; every output pixel matches the accepted sequence
        do_reset();
        for (int i = 0; i < 500; i++)
            cyc(0, ($urandom % 8) != 0, ($urandom % 10) < 7);
        repeat (40) cyc(0, 0, 1);
        chk("rand_no_drop_dup", 32'(n_en), 32'(n_acc));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_stream_tx.md
# video_stream_tx

Transmit end of the pixel-stream interface consumed by `top`: takes packed 24-bit RGB pixels from an upstream valid/ready source (frame FIFO or test pattern) and emits the `en`/`hsync`/`vsync`/`data` stream with programmable horizontal and vertical blanking. It is used as the stimulus driver in system benches and as the front end feeding the detection pipeline on hardware.

## Interface
Parameters:
- `FRAME_WIDTH`, default `` `FRAME_WIDTH ``: active pixels per line; minimum 2.
- `FRAME_HEIGHT`, default `` `FRAME_HEIGHT ``: active lines per frame; minimum 1.
- `H_BLANK`, default 16: idle cycles after each non-final line; minimum 1.
- `V_BLANK`, default 64: idle cycles after the final line of a frame; minimum 1.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  reset, synchronous and active-low.
- `run`  in  1  level; high starts and continues frames.
- `in_valid`  in  1  upstream pixel available.
- `in_data`  in  `` `PIXEL_SIZE ``  pixel data, packed as {B,G,R}.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `en`  out  1  `data` is a valid pixel this cycle.
- `hsync`  out  1  high with the first pixel of every line.
- `vsync`  out  1  high with the first pixel of every frame, coincident with `hsync`.
- `data`  out  `` `PIXEL_SIZE ``  pixel output.
- `busy`  out  1  block is not in IDLE.
- `underrun`  out  1  sticky flag: `in_valid` was low during ACTIVE.
- `frame`  out  32  count of completed frames; wraps.

## Operation
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK.
- IDLE: if `run`=1, go to ACTIVE next cycle and clear `underrun`.
- ACTIVE: `in_ready`=1. Each accepted pixel (`in_valid`&`in_ready`) advances column counter `x`.
  - At `x`=`FRAME_WIDTH`-1, `x`←0 and `y`←`y`+1.
  - After the last pixel of a non-final line, go to HBLANK.
  - After the last pixel of the final line, go to VBLANK with `y`←0.
- ACTIVE with `in_valid`=0: stall. Counters hold, `en`=0 next cycle, `underrun`←1.
- HBLANK: runs exactly `H_BLANK` cycles, then returns to ACTIVE. `in_ready`=0.
- VBLANK: runs exactly `V_BLANK` cycles; `frame` increments on entry.
  - On exit, if `run`=1, go to ACTIVE; otherwise go to IDLE.
- Dropping `run` mid-frame has no effect: the current frame, including its VBLANK, always completes.
- `in_ready` is decoded combinationally from the registered state only. It never depends on `in_valid`.
- Reset: state←IDLE; `x`, `y`, blank counter and `frame`←0; all outputs←0. A reset mid-frame abandons the frame without extra pulses.

## Timing
- Latency is 1 cycle. A pixel accepted in cycle t appears on `data` with `en`=1 in cycle t+1.
- `hsync` and `vsync` are registered alongside that pixel, computed from `x`=0 and (`x`=0, `y`=0) at acceptance.
- When `en`=0: `hsync`=0, `vsync`=0, `data`=0.
- `busy` and `frame` are registered.
- Unstalled frame period: `FRAME_WIDTH`·`FRAME_HEIGHT` + (`FRAME_HEIGHT`−1)·`H_BLANK` + `V_BLANK` cycles.
- Every stall cycle extends the period by exactly 1 cycle.
- Blank counter width is $clog2(max(`H_BLANK`,`V_BLANK`)+1). It counts down from N−1, and the state exits on 0.
- `x` and `y` widths are $clog2 of the matching frame dimension. Neither counter exceeds dimension−1.

## Structure
- Add the `TX_IDLE`/`TX_ACTIVE`/`TX_HBLANK`/`TX_VBLANK` 2-bit state encodings to `global.vh`, next to the existing `` `PIXEL_SIZE ``, `` `WORD_SIZE `` and `` `FRAME_WIDTH `` defines.
- Add `` `FRAME_HEIGHT `` to `global.vh` if it is not already there.
- Sub-module `blank_counter`:
  - loadable down-counter with `load`, `value` and `done` ports;
  - shared by HBLANK and VBLANK.
- Everything else lives in `video_stream_tx`.

## Test plan
All scenarios use `FRAME_WIDTH`=4, `FRAME_HEIGHT`=3, `H_BLANK`=2, `V_BLANK`=3.
- **Single frame.** `run` pulsed high for 1 cycle, `in_valid` held at 1, pixels 0x000001..0x00000C.
  - 12 `en` cycles, in order.
  - `hsync` on pixels 1, 5, 9; `vsync` on pixel 1 only.
  - 2 idle cycles after pixels 4 and 8.
  - `frame`=1, then IDLE with `busy`=0.
- **Continuous run.** `run` held at 1.
  - Consecutive `vsync` pulses exactly 19 cycles apart.
  - `frame` reads 1, 2, 3.
- **Stall.** `in_valid`=0 for 3 cycles on the 6th pixel.
  - `en` low for those 3 cycles; the row structure is preserved.
  - Frame period 22 cycles; `underrun`=1 until the next start from IDLE.
- **Reset mid-frame.** `reset_n`=0 for 1 cycle after pixel 7.
  - All outputs 0 and `busy`=0 next cycle.
  - Re-asserting `run` produces a full frame that begins with `vsync`.
- **Run dropped mid-frame.** `run`←0 at pixel 2.
  - The frame still completes all 12 pixels and VBLANK.
  - `frame`=1, then IDLE.
- **Handshake legality.** Random `in_valid` throughout.
  - `in_ready` is never high in HBLANK, VBLANK or IDLE.
  - Output pixel sequence equals input sequence: no drops, no duplicates.
